// File: rtl/cache_structs_def.sv
`default_nettype none
// ============================================================================
//  Package     : cache_structs_def
//  Description : Shared transaction types between the cache controllers and
//                the main memory model. A request carries chip-select,
//                read/write, block address and one full block of data; a
//                response carries a one-cycle ack and one block of data.
//  Revision    : 1.0  initial release
// ============================================================================
package cache_structs_def;

    localparam int ADDR_WIDTH = 12;
    localparam int BLOCK_SIZE = 8;      // bytes per cache block

    typedef struct packed {
        logic                       cs;     // request valid
        logic                       rw;     // 0 = read, 1 = write
        logic [ADDR_WIDTH-1:0]      addr;
        logic [BLOCK_SIZE-1:0][7:0] data;   // byte 0 in the low bits
    } memory_request_t;

    typedef struct packed {
        logic                       ack;    // one-cycle completion pulse
        logic [BLOCK_SIZE-1:0][7:0] data;
    } memory_response_t;

endpackage
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_mem_arbiter
//  Description : Shares one memory port between the I-cache (port 0) and the
//                D-cache (port 1). Round-robin arbitration, the winning request
//                is registered and held until memory acks; a watchdog aborts
//                transactions that memory never acks (sticky timeout flag).
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset
//                req_i[2]   - per-port requests, valid while .cs = 1
//                rsp_o[2]   - per-port responses (ack pulse + data), owner only
//                mem_req_o  - registered request towards memory
//                mem_rsp_i  - memory response, .ack is a one-cycle pulse
//                grant_o    - one-hot current owner, 0 when idle
//                timeout_o  - sticky watchdog error, cleared only by reset
//  Revision    : 1.0  initial release
// ============================================================================
module cache_mem_arbiter
    import cache_structs_def::*;
#(
    parameter int TIMEOUT = 256         // BUSY cycles without ack before abort (>= 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  memory_request_t  req_i [2],
    output memory_response_t rsp_o [2],
    output memory_request_t  mem_req_o,
    input  memory_response_t mem_rsp_i,
    output logic [1:0]       grant_o,
    output logic             timeout_o
);

    localparam int               TMR_W       = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] c_WDOG_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_rr_ptr;     // port preferred when both request
    logic             r_owner;      // port whose request is on mem_req_o
    logic [TMR_W-1:0] r_wdog;

    logic             w_any_req;
    logic             w_winner;

    always_comb begin
        w_any_req = req_i[0].cs | req_i[1].cs;
        if (req_i[0].cs && req_i[1].cs) begin
            w_winner = r_rr_ptr;
        end else begin
            w_winner = req_i[1].cs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= 1'b0;
            r_owner   <= 1'b0;
            r_wdog    <= '0;
            grant_o   <= 2'b00;
            timeout_o <= 1'b0;
            mem_req_o <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        // rw/addr/data copied verbatim; cs forced high below
                        mem_req_o    <= req_i[w_winner];
                        mem_req_o.cs <= 1'b1;
                        grant_o      <= w_winner ? 2'b10 : 2'b01;
                        r_owner      <= w_winner;
                        r_wdog       <= '0;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // An ack on the last watchdog cycle still completes normally
                    if (mem_rsp_i.ack) begin
                        mem_req_o.cs <= 1'b0;
                        grant_o      <= 2'b00;
                        r_rr_ptr     <= ~r_owner;
                        r_state      <= S_GAP;
                    end else if (r_wdog == c_WDOG_LAST) begin
                        // Abort; the owner keeps cs high and is re-arbitrated later
                        mem_req_o.cs <= 1'b0;
                        grant_o      <= 2'b00;
                        timeout_o    <= 1'b1;
                        r_rr_ptr     <= ~r_owner;
                        r_state      <= S_GAP;
                    end else begin
                        r_wdog <= r_wdog + TMR_W'(1);
                    end
                end
                S_GAP: begin
                    // Lets the finished requester's cs drop before re-arbitrating
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Responses are forwarded combinationally, to the owner only and only in BUSY
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rsp_o[i] = '0;
            if ((r_state == S_BUSY) && mem_rsp_i.ack && (r_owner == 1'(i))) begin
                rsp_o[i].ack  = 1'b1;
                rsp_o[i].data = mem_rsp_i.data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_mem_arbiter
//  Description : Self-checking bench for cache_mem_arbiter. Directed scenarios
//                followed by randomized traffic, all compared every cycle
//                against a transaction-level reference model (round-robin by
//                last-served port, one idle gap plus one arbitration cycle
//                between transactions, abort when memory latency reaches
//                TIMEOUT).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cache_mem_arbiter;
    import cache_structs_def::*;

    localparam int TIMEOUT = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    memory_request_t  req [2];
    memory_response_t rsp [2];
    memory_request_t  mem_req;
    memory_response_t mem_rsp;
    logic [1:0]       grant;
    logic             timeout;

    int checks = 0;
    int errors = 0;

    cache_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (req),
        .rsp_o     (rsp),
        .mem_req_o (mem_req),
        .mem_rsp_i (mem_rsp),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit              m_busy, m_tmo, prev_free, random_mode, force_stray;
    int              m_owner, m_last, m_k, m_lat, since_done, plan_lat;
    memory_request_t m_req;
    logic [63:0]     m_data;
    int              obs_acks [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_tmo      = 1'b0;
        m_last     = 1;         // so port 0 is preferred first
        since_done = 100;
        prev_free  = 1'b1;
        plan_lat   = -1;
    endtask

    task automatic raise(input int p, input logic rw, input logic [11:0] addr,
                         input logic [63:0] data);
        req[p].rw   = rw;
        req[p].addr = addr;
        req[p].data = data;
        req[p].cs   = 1'b1;
    endtask

    // One clock cycle: update model for the edge just passed, drive memory,
    // check all outputs, then play requester/memory for the next edge.
    task automatic cycle();
        bit ack_now;
        bit exp_ack;
        bit dropped [2] = '{1'b0, 1'b0};
        @(negedge clk);
        if (m_busy) begin
            m_k++;
        end else if (prev_free && (req[0].cs || req[1].cs)) begin
            if (req[0].cs && req[1].cs) m_owner = 1 - m_last;
            else                        m_owner = req[1].cs ? 1 : 0;
            m_busy   = 1'b1;
            m_k      = 0;
            m_req    = req[m_owner];
            m_lat    = (plan_lat >= 0) ? plan_lat : int'($urandom_range(0, TIMEOUT + 1));
            plan_lat = -1;
            m_data   = {$urandom, $urandom};
        end
        if (since_done < 1000) since_done++;

        if (m_busy) ack_now = (m_k == m_lat);
        else        ack_now = force_stray || (random_mode && ($urandom_range(0, 7) == 0));
        mem_rsp.ack  = ack_now;
        mem_rsp.data = m_busy ? m_data : {$urandom, $urandom};
        #1;

        chk("mem_cs", mem_req.cs, m_busy);
        chk("grant", grant, m_busy ? (2'b01 << m_owner) : 2'b00);
        chk("timeout", timeout, m_tmo);
        if (m_busy) begin
            chk("mem_addr", mem_req.addr, m_req.addr);
            chk("mem_rw", mem_req.rw, m_req.rw);
            chk("mem_data", mem_req.data, m_req.data);
        end
        for (int i = 0; i < 2; i++) begin
            exp_ack = m_busy && ack_now && (m_owner == i);
            chk(i == 0 ? "rsp0_ack" : "rsp1_ack", rsp[i].ack, exp_ack);
            if (exp_ack) chk(i == 0 ? "rsp0_data" : "rsp1_data", rsp[i].data, m_data);
            if (rsp[i].ack === 1'b1) obs_acks[i]++;
        end

        if (m_busy && (ack_now || (m_k == TIMEOUT - 1))) begin
            if (ack_now) begin
                req[m_owner].cs  = 1'b0;
                dropped[m_owner] = 1'b1;
            end else begin
                m_tmo = 1'b1;
            end
            m_busy     = 1'b0;
            m_last     = m_owner;
            since_done = 0;
        end
        prev_free = !m_busy && (since_done >= 2);

        if (random_mode) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i].cs && !dropped[i] && ($urandom_range(0, 3) == 0)) begin
                    raise(i, 1'($urandom_range(0, 1)), ADDR_WIDTH'($urandom),
                          {$urandom, $urandom});
                end
            end
        end
    endtask

    task automatic wait_grant(input string tag, input logic [1:0] exp);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (grant === 2'b00 && n < 30);
        chk(tag, grant, exp);
    endtask

    task automatic wait_done(input string tag, output int busy_cycles);
        int n = 0;
        busy_cycles = 1;
        while (mem_req.cs === 1'b1 && n < 30) begin
            cycle();
            n++;
            if (mem_req.cs === 1'b1) busy_cycles++;
        end
        chk(tag, mem_req.cs, 1'b0);
    endtask

    initial begin
        int nb;
        int a0, a1;
        for (int i = 0; i < 2; i++) begin
            req[i]      = '0;
            obs_acks[i] = 0;
        end
        mem_rsp     = '0;
        random_mode = 1'b0;
        force_stray = 1'b0;
        rst_n       = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_mem_req", mem_req, '0);
        chk("rst_grant", grant, 2'b00);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_rsp0", rsp[0], '0);
        chk("rst_rsp1", rsp[1], '0);
        rst_n = 1'b1;

        // T2: simultaneous requests, then contention again with rr moved on
        raise(0, 1'b0, 12'h100, 64'h0);
        raise(1, 1'b0, 12'h200, 64'h0);
        plan_lat = 1;
        wait_grant("t2_first_p0", 2'b01);
        wait_done("t2_done0", nb);
        raise(0, 1'b0, 12'h104, 64'h0);     // re-request during the gap
        plan_lat = 0;
        wait_grant("t2_rr_p1", 2'b10);
        wait_done("t2_done1", nb);
        plan_lat = 2;
        wait_grant("t2_then_p0", 2'b01);
        wait_done("t2_done2", nb);

        // T1: single read, memory acks on the third BUSY cycle
        a0 = obs_acks[0];
        raise(0, 1'b0, 12'h0A8, 64'h0);
        plan_lat = 2;
        wait_grant("t1_grant", 2'b01);
        chk("t1_addr", mem_req.addr, 12'h0A8);
        chk("t1_rw", mem_req.rw, 1'b0);
        wait_done("t1_done", nb);
        chk("t1_busy_cycles", nb, 3);
        chk("t1_ack_count", obs_acks[0], a0 + 1);
        cycle();
        chk("t1_gap_cs", mem_req.cs, 1'b0);

        // T3: write from port 1 arrives while port 0 is busy
        raise(0, 1'b0, 12'h055, 64'h0);
        plan_lat = 3;
        wait_grant("t3_p0", 2'b01);
        raise(1, 1'b1, 12'h3F0, 64'h1817161514131211);
        plan_lat = 1;
        wait_done("t3_done0", nb);
        wait_grant("t3_p1", 2'b10);
        chk("t3_addr", mem_req.addr, 12'h3F0);
        chk("t3_rw", mem_req.rw, 1'b1);
        chk("t3_data", mem_req.data, 64'h1817161514131211);
        wait_done("t3_done1", nb);

        // T5: ack on the last watchdog cycle completes normally
        a0 = obs_acks[0];
        raise(0, 1'b0, 12'h7FF, 64'h0);
        plan_lat = TIMEOUT - 1;
        wait_grant("t5_grant", 2'b01);
        wait_done("t5_done", nb);
        chk("t5_busy_cycles", nb, TIMEOUT);
        chk("t5_timeout", timeout, 1'b0);
        chk("t5_ack_count", obs_acks[0], a0 + 1);

        // T4: memory never acks; abort, sticky flag, same port retried
        a1 = obs_acks[1];
        raise(1, 1'b0, 12'h444, 64'h0);
        plan_lat = 99;
        wait_grant("t4_grant", 2'b10);
        wait_done("t4_abort", nb);
        chk("t4_busy_cycles", nb, TIMEOUT);
        chk("t4_no_ack", obs_acks[1], a1);
        chk("t4_timeout_set", timeout, 1'b1);
        plan_lat = 1;
        wait_grant("t4_regrant", 2'b10);
        wait_done("t4_retry_done", nb);
        chk("t4_retry_ack", obs_acks[1], a1 + 1);
        chk("t4_timeout_sticky", timeout, 1'b1);

        // T6: reset in the middle of BUSY, then stray memory acks
        raise(0, 1'b0, 12'h321, 64'h0);
        plan_lat = 99;
        wait_grant("t6_grant", 2'b01);
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_cs", mem_req.cs, 1'b0);
        chk("t6_async_grant", grant, 2'b00);
        chk("t6_async_timeout", timeout, 1'b0);
        @(negedge clk);
        req[0].cs = 1'b0;
        req[1].cs = 1'b0;
        rst_n     = 1'b1;
        model_reset();
        a0 = obs_acks[0];
        a1 = obs_acks[1];
        force_stray = 1'b1;
        repeat (3) cycle();
        force_stray = 1'b0;
        chk("t6_stray_ack0", obs_acks[0], a0);
        chk("t6_stray_ack1", obs_acks[1], a1);

        // Randomized traffic, latencies and stray acks
        random_mode = 1'b1;
        repeat (1500) cycle();
        random_mode = 1'b0;
        repeat (20) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
